// File: rtl/rvr32_ifu.sv
`default_nettype none
// ============================================================================
// Module   : rvr32_ifu
// Brief    : Instruction fetch unit with a direct-mapped read-only I-cache.
//            Optional hit/miss counters are enabled by RVR32_IFU_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rvr32_ifu #(
   parameter int NLINES     = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_addr,
   input  logic        flush,
   output logic [31:0] inst_data,
   output logic        inst_ready,
   output logic [31:0] mem_addr,
   output logic        mem_valid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
`ifdef RVR32_IFU_PERF_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int c_INDEX_BITS  = $clog2(NLINES);
   localparam int c_OFFSET_BITS = $clog2(LINE_WORDS);
   localparam int c_ADDR_BITS   = c_INDEX_BITS + c_OFFSET_BITS;
   localparam int c_TAG_BITS    = 30 - c_ADDR_BITS;
   localparam logic [c_OFFSET_BITS-1:0] c_LAST_BEAT = c_OFFSET_BITS'(LINE_WORDS - 1);

   typedef enum logic [0:0] {
      S_LOOKUP = 1'b0,
      S_REFILL = 1'b1
   } state_t;

   state_t                   r_state;
   state_t                   w_state_next;

   logic [c_TAG_BITS-1:0]    w_tag;
   logic [c_INDEX_BITS-1:0]  w_index;
   logic [c_OFFSET_BITS-1:0] w_offset;
   logic                     w_unused_addr_bits;

   logic [NLINES-1:0]        r_valid;
   logic [c_TAG_BITS-1:0]    r_tags [NLINES];
   logic [31:0]              r_data [NLINES*LINE_WORDS];

   logic [c_TAG_BITS-1:0]    r_miss_tag;
   logic [c_INDEX_BITS-1:0]  r_miss_index;
   logic [c_OFFSET_BITS-1:0] r_beat;
   logic                     r_flush_seen;
   logic                     r_inst_ready;
   logic [31:0]              r_inst_data;

   logic                     w_hit;
   logic                     w_lookup;
   logic                     w_beat_done;
   logic                     w_last_beat;

   assign w_offset           = inst_addr[c_OFFSET_BITS+1:2];
   assign w_index            = inst_addr[c_ADDR_BITS+1:c_OFFSET_BITS+2];
   assign w_tag              = inst_addr[31:c_ADDR_BITS+2];
   assign w_unused_addr_bits = &{1'b0, inst_addr[1:0]};

   // A flush cycle is neither a hit nor a miss: it only invalidates.
   assign w_hit       = r_valid[w_index] && (r_tags[w_index] == w_tag);
   assign w_lookup    = (r_state == S_LOOKUP) && !flush;
   assign w_beat_done = (r_state == S_REFILL) && mem_ready;
   assign w_last_beat = w_beat_done && (r_beat == c_LAST_BEAT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_LOOKUP;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_LOOKUP: if (w_lookup && !w_hit) w_state_next = S_REFILL;
         S_REFILL: if (w_last_beat)        w_state_next = S_LOOKUP;
         default:                          w_state_next = S_LOOKUP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid      <= '0;
         r_inst_ready <= 1'b0;
         r_inst_data  <= '0;
         r_miss_tag   <= '0;
         r_miss_index <= '0;
         r_beat       <= '0;
         r_flush_seen <= 1'b0;
      end else begin
         r_inst_ready <= w_lookup && w_hit;
         if (w_lookup && w_hit) begin
            r_inst_data <= r_data[{w_index, w_offset}];
         end
         if (w_lookup && !w_hit) begin
            r_miss_tag   <= w_tag;
            r_miss_index <= w_index;
            r_beat       <= '0;
            r_flush_seen <= 1'b0;
         end
         if (w_beat_done) begin
            r_beat <= r_beat + c_OFFSET_BITS'(1);
         end
         if ((r_state == S_REFILL) && flush) begin
            r_flush_seen <= 1'b1;
         end
         // A flush seen anywhere in the refill, including the last beat, keeps the line invalid.
         if (flush) begin
            r_valid <= '0;
         end else if (w_last_beat && !r_flush_seen) begin
            r_valid[r_miss_index] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_beat_done) begin
         r_data[{r_miss_index, r_beat}] <= mem_rdata;
      end
      if (w_last_beat) begin
         r_tags[r_miss_index] <= r_miss_tag;
      end
   end

   assign inst_ready = r_inst_ready;
   assign inst_data  = r_inst_data;
   assign mem_valid  = (r_state == S_REFILL);
   assign mem_addr   = {r_miss_tag, r_miss_index, r_beat, 2'b00};

`ifdef RVR32_IFU_PERF_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_lookup) begin
         if (w_hit) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end else begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvr32_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvr32_ifu
// Brief    : Directed scoreboard bench for rvr32_ifu against a word-indexed
//            memory model (word n reads as 0xA000_0000 + n).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvr32_ifu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b1;
   logic [31:0] inst_addr = 32'h0;
   logic [31:0] inst_data;
   logic        inst_ready;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        bp_mode = 1'b0;
   logic [1:0]  bp_cnt;
`ifdef RVR32_IFU_PERF_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int          total = 0;
   int          bad = 0;
   logic [31:0] q_data[$];
   logic [31:0] q_addr[$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = 32'h0;

   rvr32_ifu #(.NLINES(16), .LINE_WORDS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_addr  (inst_addr),
      .flush      (flush),
      .inst_data  (inst_data),
      .inst_ready (inst_ready),
      .mem_addr   (mem_addr),
      .mem_valid  (mem_valid),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
`ifdef RVR32_IFU_PERF_EN
      ,
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: optional backpressure accepts one beat every fourth cycle.
   assign mem_rdata = 32'hA000_0000 + {2'b00, mem_addr[31:2]};
   assign mem_ready = bp_mode ? (bp_cnt == 2'd3) : 1'b1;

   always @(posedge clk or posedge rst) begin
      if (rst) bp_cnt <= 2'd0;
      else if (bp_mode && mem_valid) bp_cnt <= mem_ready ? 2'd0 : bp_cnt + 2'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_line(input logic [31:0] addr);
      for (int i = 0; i < 4; i++) q_addr.push_back({addr[31:4], 4'h0} + 32'(4 * i));
   endtask

   task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, output int lat);
      flush     = 1'b0;
      inst_addr = addr;
      q_data.push_back(exp);
      lat = 0;
      while (1) begin
         step();
         lat++;
         if (inst_ready) break;
         if (lat >= 100) begin
            chk("fetch_timeout", {31'b0, inst_ready}, 32'd1);
            break;
         end
      end
   endtask

   task automatic park();
      flush = 1'b1;
      step();
      step();
   endtask

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (inst_ready) begin
            if (q_data.size() == 0) chk("inst_unexpected", {31'b0, inst_ready}, 32'd0);
            else chk("inst_data", inst_data, q_data.pop_front());
         end
         if (mem_valid && mem_ready) begin
            if (q_addr.size() == 0) chk("beat_unexpected", {31'b0, mem_valid}, 32'd0);
            else chk("mem_addr", mem_addr, q_addr.pop_front());
         end
         if (mem_valid) chk("ready_in_refill", {31'b0, inst_ready}, 32'd0);
         if (prev_stall) begin
            chk("stall_valid", {31'b0, mem_valid}, 32'd1);
            chk("stall_addr", mem_addr, prev_addr);
         end
         prev_stall = mem_valid && !mem_ready;
         prev_addr  = mem_addr;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      step();
      step();
      chk("rst_inst_ready", {31'b0, inst_ready}, 32'd0);
      chk("rst_inst_data", inst_data, 32'd0);
      chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      rst = 1'b0;
      step();

      // Cold miss then sequential hits
      push_line(32'h100);
      fetch(32'h100, 32'hA000_0040, lat); chk("cold_lat", 32'(lat), 32'd6);
      fetch(32'h104, 32'hA000_0041, lat); chk("hit_lat_104", 32'(lat), 32'd1);
      fetch(32'h108, 32'hA000_0042, lat); chk("hit_lat_108", 32'(lat), 32'd1);
      flush = 1'b1;
      step();
      chk("flush_ready", {31'b0, inst_ready}, 32'd0);
      step();

      // Conflict eviction on index 0
      push_line(32'h100);
      fetch(32'h100, 32'hA000_0040, lat); chk("evict_lat_a", 32'(lat), 32'd6);
      push_line(32'h500);
      fetch(32'h500, 32'hA000_0140, lat); chk("evict_lat_b", 32'(lat), 32'd6);
      push_line(32'h100);
      fetch(32'h100, 32'hA000_0040, lat); chk("evict_lat_c", 32'(lat), 32'd6);
      fetch(32'h10C, 32'hA000_0043, lat); chk("evict_hit_lat", 32'(lat), 32'd1);
      park();

      // Bus backpressure
      bp_mode = 1'b1;
      push_line(32'h100);
      fetch(32'h100, 32'hA000_0040, lat); chk("bp_lat", 32'(lat), 32'd18);
      bp_mode = 1'b0;
      fetch(32'h104, 32'hA000_0041, lat); chk("bp_hit_lat", 32'(lat), 32'd1);
      park();

      // Flush during beat 2: line must refill a second time
      flush = 1'b0;
      inst_addr = 32'h100;
      push_line(32'h100);
      push_line(32'h100);
      q_data.push_back(32'hA000_0040);
      lat = 0;
      while (1) begin
         step();
         lat++;
         if (lat == 3) flush = 1'b1;
         if (lat == 4) flush = 1'b0;
         if (inst_ready) break;
         if (lat >= 100) begin
            chk("flush_timeout", {31'b0, inst_ready}, 32'd1);
            break;
         end
      end
      chk("flush_refill_lat", 32'(lat), 32'd11);
      park();

      // Reset while beat 1 is presented
      flush = 1'b0;
      inst_addr = 32'h100;
      push_line(32'h100);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("midrst_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("midrst_inst_ready", {31'b0, inst_ready}, 32'd0);
      chk("midrst_mem_addr", mem_addr, 32'd0);
      chk("midrst_inst_data", inst_data, 32'd0);
      q_addr.delete();
      step();
      rst = 1'b0;
      push_line(32'h100);
      fetch(32'h100, 32'hA000_0040, lat); chk("post_rst_lat", 32'(lat), 32'd6);
      park();

      chk("q_data_left", 32'(q_data.size()), 32'd0);
      chk("q_addr_left", 32'(q_addr.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
